// File: rtl/hazard_scoreboard.sv
// Register scoreboard interlock: load-latency countdowns plus one mul/div tracker.
// Optional HAZARD_STATS_EN adds stall_cycles / md_stall_cycles counters.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_ir,
  input  logic [31:0] dx_ir,
  input  logic        dx_issue,
  input  logic        md_done,
  output logic        stall,
  output logic        md_busy,
  output logic [4:0]  md_rd
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles
`endif
);

  localparam logic [4:0] OP_RT   = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;
  localparam logic [4:0] AL_MUL  = 5'b00110;
  localparam logic [4:0] AL_DIV  = 5'b00111;

  localparam logic [CNT_W-1:0] LD_VAL = CNT_W'(LOAD_LAT - 1);
  localparam logic LD_EN = (LOAD_LAT > 1);

  typedef enum logic {S_IDLE, S_BUSY} md_state_e;

  logic [4:0]       w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt;
  logic [4:0]       w_dx_op, w_dx_rd, w_dx_al;
  logic             w_rs_en, w_rt_en, w_rd_en;
  logic             w_dx_lw, w_dx_md;
  logic             w_dx_hit, w_md_hit, w_pend_hit;
  logic             w_term_a, w_term_b, w_term_c;
  logic             w_term_d, w_term_e;
  logic             w_ld_issue, w_md_issue;
  logic [31:0]      w_pend;
  logic [CNT_W-1:0] r_cnt [NUM_REGS];
  md_state_e        r_state, w_state_nxt;
  logic [4:0]       r_md_rd, w_md_rd_nxt;
  logic             w_unused;

  function automatic logic f_hit(
    input logic       en,
    input logic [4:0] src,
    input logic [4:0] dst
  );
    return en && (src != 5'd0) && (src == dst);
  endfunction

  assign w_fd_op = fd_ir[31:27];
  assign w_fd_rd = fd_ir[26:22];
  assign w_fd_rs = fd_ir[21:17];
  assign w_fd_rt = fd_ir[16:12];
  assign w_dx_op = dx_ir[31:27];
  assign w_dx_rd = dx_ir[26:22];
  assign w_dx_al = dx_ir[6:2];

  assign w_unused = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

  assign w_rs_en = !(w_fd_op inside {OP_J, OP_JAL, OP_SETX, OP_BEX});
  assign w_rt_en = (w_fd_op == OP_RT);
  assign w_rd_en = w_fd_op inside {OP_SW, OP_BNE, OP_BLT, OP_JR};

  assign w_dx_lw = (w_dx_op == OP_LW);
  assign w_dx_md = (w_dx_op == OP_RT) &&
                   ((w_dx_al == AL_MUL) || (w_dx_al == AL_DIV));

  assign w_dx_hit = f_hit(w_rs_en, w_fd_rs, w_dx_rd) |
                    f_hit(w_rt_en, w_fd_rt, w_dx_rd) |
                    f_hit(w_rd_en, w_fd_rd, w_dx_rd);

  // md_rd == 0 can never match a nonzero source, so rd0 mul/div is structural only
  assign w_md_hit = f_hit(w_rs_en, w_fd_rs, r_md_rd) |
                    f_hit(w_rt_en, w_fd_rt, r_md_rd) |
                    f_hit(w_rd_en, w_fd_rd, r_md_rd);

  always_comb begin
    w_pend = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_pend[i] = (r_cnt[i] != '0);
    end
  end

  assign w_pend_hit = (w_rs_en && w_pend[w_fd_rs]) |
                      (w_rt_en && w_pend[w_fd_rt]) |
                      (w_rd_en && w_pend[w_fd_rd]);

  assign w_term_a = w_dx_lw && w_dx_hit;
  assign w_term_b = w_dx_md && w_dx_hit;
  assign w_term_c = w_pend_hit;
  assign w_term_d = md_busy && w_md_hit;
  assign w_term_e = md_busy && w_dx_md && !md_done;

  assign stall = w_term_a | w_term_b | w_term_c | w_term_d | w_term_e;

  assign w_ld_issue = LD_EN && dx_issue && w_dx_lw && (w_dx_rd != 5'd0);

  // a fresh load to a register overrides its decrement this cycle
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        r_cnt[i] <= '0;
      end else if (w_ld_issue && (w_dx_rd == 5'(i))) begin
        r_cnt[i] <= LD_VAL;
      end else if (r_cnt[i] != '0) begin
        r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  assign w_md_issue = dx_issue && w_dx_md;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_md_rd <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_md_rd <= w_md_rd_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_md_rd_nxt = r_md_rd;
    unique case (r_state)
      S_IDLE: begin
        if (w_md_issue) begin
          w_state_nxt = S_BUSY;
          w_md_rd_nxt = w_dx_rd;
        end
      end
      S_BUSY: begin
        if (w_md_issue) begin
          w_state_nxt = S_BUSY;
          w_md_rd_nxt = w_dx_rd;
        end else if (md_done) begin
          w_state_nxt = S_IDLE;
          w_md_rd_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_md_rd_nxt = '0;
      end
    endcase
  end

  assign md_busy = (r_state == S_BUSY);
  assign md_rd   = r_md_rd;

`ifdef HAZARD_STATS_EN
  logic        w_md_term;
  logic [31:0] r_stall_cnt, r_md_stall_cnt;

  assign w_md_term = w_term_b | w_term_d | w_term_e;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt    <= '0;
      r_md_stall_cnt <= '0;
    end else begin
      if (stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_md_term) r_md_stall_cnt <= r_md_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles    = r_stall_cnt;
  assign md_stall_cycles = r_md_stall_cnt;
`endif

endmodule
